// File: rtl/seqmul_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
// Holds the controller state encoding and the counter-width function.
package seqmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2, used to size the iteration counter (WIDTH >= 2 gives >= 1 bit).
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result++;
    end
    return result;
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Operand/result handshake bundle for seq_multiplier (acc exists only with SEQMUL_ACC_EN).
// master = producer/consumer side, slave = the multiplier.
interface seq_multiplier_if #(parameter int WIDTH = 8);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 signed_mode;
`ifdef SEQMUL_ACC_EN
  logic                 acc;
`endif
  logic                 busy;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   p;

`ifdef SEQMUL_ACC_EN
  modport master (
    output in_valid, a, b, signed_mode, acc, out_ready,
    input  in_ready, busy, out_valid, p
  );

  modport slave (
    input  in_valid, a, b, signed_mode, acc, out_ready,
    output in_ready, busy, out_valid, p
  );
`else
  modport master (
    output in_valid, a, b, signed_mode, out_ready,
    input  in_ready, busy, out_valid, p
  );

  modport slave (
    input  in_valid, a, b, signed_mode, out_ready,
    output in_ready, busy, out_valid, p
  );
`endif

endinterface

// File: rtl/seqmul_addsub.sv
// Combinational accumulator update: adds or subtracts the shifted, extended
// multiplicand. Subtraction is used for the sign bit of a two's-complement multiplier.
module seqmul_addsub #(
  parameter int PW = 16
) (
  input  logic [PW-1:0] accum,
  input  logic [PW-1:0] addend,
  input  logic          sub,
  output logic [PW-1:0] result
);

  assign result = sub ? (accum - addend) : (accum + addend);

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add WIDTH x WIDTH multiplier, one partial product per clock.
// Optional multiply-accumulate (acc port, preload from p) is enabled by SEQMUL_ACC_EN.
module seq_multiplier
  import seqmul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  seq_multiplier_if.slave  bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = clog2(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             signed_q, signed_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [PW-1:0]    accum_q, accum_d;
  logic [PW-1:0]    p_q, p_d;

  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    sum;
  logic             last_iter;
  logic             acc_req;

`ifdef SEQMUL_ACC_EN
  assign acc_req = bus.acc;
`else
  assign acc_req = 1'b0;
`endif

  assign a_ext     = signed_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign last_iter = (cnt_q == CW'(WIDTH - 1));
  assign addend    = b_q[cnt_q] ? (a_ext << cnt_q) : '0;

  // In signed mode the multiplier's MSB carries weight -2^(W-1), hence the subtract.
  seqmul_addsub #(.PW(PW)) u_addsub (
    .accum  (accum_q),
    .addend (addend),
    .sub    (signed_q & last_iter),
    .result (sum)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    cnt_d    = cnt_q;
    accum_d  = accum_q;
    p_d      = p_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d      = bus.a;
          b_d      = bus.b;
          signed_d = bus.signed_mode;
          accum_d  = acc_req ? p_q : '0;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        accum_d = sum;
        cnt_d   = cnt_q + 1'b1;
        if (last_iter) begin
          p_d     = sum;
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      cnt_q    <= '0;
      accum_q  <= '0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      cnt_q    <= cnt_d;
      accum_q  <= accum_d;
      p_q      <= p_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q == RUN);
  assign bus.out_valid = (state_q == DONE);
  assign bus.p         = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and randomised self-checking bench for seq_multiplier (WIDTH=8 and WIDTH=4).
// Covers latency, stall hold, mid-run reset and, with SEQMUL_ACC_EN, accumulate chains.
module tb_seq_multiplier;

  localparam int W8 = 8;
  localparam int W4 = 4;

  logic clk;
  logic rst;
  int   assertCount;
  int   failCount;

  seq_multiplier_if #(.WIDTH(W8)) w8_if ();
  seq_multiplier_if #(.WIDTH(W4)) w4_if ();

  seq_multiplier #(.WIDTH(W8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (w8_if)
  );

  seq_multiplier #(.WIDTH(W4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (w4_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Independent reference: exact product truncated to 16 bits.
  function automatic logic [15:0] refProduct(input logic [7:0] av, input logic [7:0] bv, input logic sm);
    logic signed [15:0] sres;
    logic [15:0]        ures;
    if (sm) begin
      sres = $signed(av) * $signed(bv);
      return sres;
    end
    ures = {8'h00, av} * {8'h00, bv};
    return ures;
  endfunction

  // One full WIDTH=8 operation from IDLE back to IDLE, with a post-result stall.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic sm,
                               input logic accv, input logic [15:0] expP, input string tag,
                               input int stall);
    int cyc;
    @(negedge clk);
    checkOutput({tag, "_in_ready"}, 32'(w8_if.in_ready), 32'd1);
    w8_if.in_valid    = 1'b1;
    w8_if.a           = av;
    w8_if.b           = bv;
    w8_if.signed_mode = sm;
`ifdef SEQMUL_ACC_EN
    w8_if.acc         = accv;
`endif
    w8_if.out_ready   = 1'b0;
    @(posedge clk);
    #1;
    w8_if.in_valid    = 1'b0;
    w8_if.a           = ~av;
    w8_if.b           = ~bv;
    w8_if.signed_mode = ~sm;
`ifdef SEQMUL_ACC_EN
    w8_if.acc         = ~accv;
`endif
    cyc = 1;
    while (!w8_if.out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput({tag, "_latency"}, 32'(cyc), 32'(W8 + 1));
    checkOutput({tag, "_p"}, 32'(w8_if.p), 32'(expP));
    repeat (stall) @(posedge clk);
    #1;
    w8_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    w8_if.out_ready = 1'b0;
  endtask

  task automatic applyStimulusNarrow(input logic [3:0] av, input logic [3:0] bv, input logic sm,
                                     input logic [7:0] expP, input string tag);
    int cyc;
    @(negedge clk);
    w4_if.in_valid    = 1'b1;
    w4_if.a           = av;
    w4_if.b           = bv;
    w4_if.signed_mode = sm;
    @(posedge clk);
    #1;
    w4_if.in_valid    = 1'b0;
    w4_if.a           = 4'h0;
    w4_if.b           = 4'h0;
    cyc = 1;
    while (!w4_if.out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput({tag, "_latency"}, 32'(cyc), 32'(W4 + 1));
    checkOutput({tag, "_p"}, 32'(w4_if.p), 32'(expP));
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    logic       rsm;
    logic       sawValid;
    int         cyc;

    assertCount = 0;
    failCount   = 0;
    rst = 1'b1;
    w8_if.in_valid = 1'b0; w8_if.a = '0; w8_if.b = '0; w8_if.signed_mode = 1'b0; w8_if.out_ready = 1'b0;
    w4_if.in_valid = 1'b0; w4_if.a = '0; w4_if.b = '0; w4_if.signed_mode = 1'b0; w4_if.out_ready = 1'b1;
`ifdef SEQMUL_ACC_EN
    w8_if.acc = 1'b0;
    w4_if.acc = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    checkOutput("reset_in_ready", 32'(w8_if.in_ready), 32'd1);
    checkOutput("reset_out_valid", 32'(w8_if.out_valid), 32'd0);
    checkOutput("reset_busy", 32'(w8_if.busy), 32'd0);
    checkOutput("reset_p", 32'(w8_if.p), 32'd0);

    $display("[TB] WIDTH=4 corner products");
    applyStimulusNarrow(4'hF, 4'hF, 1'b0, 8'hE1, "w4_uns_ff");
    applyStimulusNarrow(4'hF, 4'hF, 1'b1, 8'h01, "w4_sgn_ff");
    applyStimulusNarrow(4'h8, 4'h8, 1'b1, 8'h40, "w4_sgn_min");

    $display("[TB] WIDTH=8 directed vectors");
    applyStimulus(8'h80, 8'h80, 1'b1, 1'b0, 16'h4000, "s_min_min", 0);
    applyStimulus(8'h80, 8'h7F, 1'b1, 1'b0, 16'hC080, "s_min_max", 1);
    applyStimulus(8'hFF, 8'h02, 1'b1, 1'b0, 16'hFFFE, "s_m1_2", 0);
    applyStimulus(8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01, "u_max", 2);
    applyStimulus(8'h00, 8'hA5, 1'b0, 1'b0, 16'h0000, "u_zero", 0);
    applyStimulus(8'h07, 8'hF9, 1'b1, 1'b0, 16'hFFCF, "s_7_m7", 0);

    $display("[TB] Output stall with competing in_valid");
    @(negedge clk);
    w8_if.in_valid = 1'b1; w8_if.a = 8'h12; w8_if.b = 8'h34; w8_if.signed_mode = 1'b0;
    @(posedge clk);
    #1;
    w8_if.in_valid = 1'b0;
    cyc = 1;
    while (!w8_if.out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    checkOutput("stall_latency", 32'(cyc), 32'(W8 + 1));
    w8_if.in_valid = 1'b1; w8_if.a = 8'h55; w8_if.b = 8'h66;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      checkOutput("stall_out_valid", 32'(w8_if.out_valid), 32'd1);
      checkOutput("stall_p", 32'(w8_if.p), 32'h03A8);
      checkOutput("stall_in_ready", 32'(w8_if.in_ready), 32'd0);
    end
    w8_if.in_valid  = 1'b0;
    w8_if.out_ready = 1'b1;
    @(posedge clk);
    #1;
    w8_if.out_ready = 1'b0;
    checkOutput("release_in_ready", 32'(w8_if.in_ready), 32'd1);
    checkOutput("release_out_valid", 32'(w8_if.out_valid), 32'd0);
    checkOutput("release_busy", 32'(w8_if.busy), 32'd0);
    checkOutput("release_p_held", 32'(w8_if.p), 32'h03A8);

    $display("[TB] Reset during RUN");
    @(negedge clk);
    w8_if.in_valid = 1'b1; w8_if.a = 8'd200; w8_if.b = 8'd100; w8_if.signed_mode = 1'b0;
    @(posedge clk);
    #1;
    w8_if.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("midrun_busy", 32'(w8_if.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_in_ready", 32'(w8_if.in_ready), 32'd1);
    checkOutput("rst_busy", 32'(w8_if.busy), 32'd0);
    checkOutput("rst_out_valid", 32'(w8_if.out_valid), 32'd0);
    checkOutput("rst_p", 32'(w8_if.p), 32'd0);
    sawValid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (w8_if.out_valid) sawValid = 1'b1;
    end
    checkOutput("rst_no_out_valid", 32'(sawValid), 32'd0);
    applyStimulus(8'd3, 8'd5, 1'b0, 1'b0, 16'd15, "post_rst", 0);

`ifdef SEQMUL_ACC_EN
    $display("[TB] Multiply-accumulate chain");
    applyStimulus(8'd3, 8'd4, 1'b0, 1'b0, 16'd12, "mac_first", 0);
    applyStimulus(8'd5, 8'd6, 1'b0, 1'b1, 16'd42, "mac_acc", 0);
    applyStimulus(8'd2, 8'd2, 1'b0, 1'b0, 16'd4, "mac_clear", 0);
`endif

    $display("[TB] Random operands with output stalls");
    for (int n = 0; n < 1000; n++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rsm = 1'($urandom_range(0, 1));
      applyStimulus(ra, rb, rsm, 1'b0, refProduct(ra, rb, rsm), "rand", $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
